// File: rtl/bcd_ms_timer_if.sv
// Control and digit bundle between the game controller and bcd_ms_timer.
// The lap input exists only when BCD_MS_TIMER_LAP_EN is defined.
interface bcd_ms_timer_if;
    logic       start;
    logic       stop;
    logic       clear;
`ifdef BCD_MS_TIMER_LAP_EN
    logic       lap;
`endif
    logic [3:0] ones;
    logic [3:0] tenths;
    logic [3:0] hundreths;
    logic [3:0] thousandths;
    logic       running;
    logic       done;
    logic       overflow;

    modport master (
`ifdef BCD_MS_TIMER_LAP_EN
        output lap,
`endif
        output start, stop, clear,
        input  ones, tenths, hundreths, thousandths,
        input  running, done, overflow
    );

    modport slave (
`ifdef BCD_MS_TIMER_LAP_EN
        input  lap,
`endif
        input  start, stop, clear,
        output ones, tenths, hundreths, thousandths,
        output running, done, overflow
    );
endinterface

// File: rtl/bcd_ms_timer.sv
// Millisecond BCD stopwatch X.XXX s with start/stop/clear FSM.
// Optional lap freeze of the displayed digits: define BCD_MS_TIMER_LAP_EN.
module bcd_ms_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic          clk,
    input  logic          reset_n,
    bcd_ms_timer_if.slave bus
);
    localparam int PRE_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_OVF} state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [3:0]       r_ones;
    logic [3:0]       r_tenths;
    logic [3:0]       r_hund;
    logic [3:0]       r_thou;
    logic             r_running;
    logic             r_done;
    logic             r_overflow;

    logic w_tick;
    logic w_c0;
    logic w_c1;
    logic w_c2;
    logic w_max;

    function automatic logic [3:0] f_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    assign w_tick = (r_state == S_RUN) && (r_pre == PRE_W'(TICK_DIV - 1));
    // Carry chain resolved combinationally so 0.999 -> 1.000 in one edge
    assign w_c0   = (r_thou == 4'd9);
    assign w_c1   = w_c0 && (r_hund == 4'd9);
    assign w_c2   = w_c1 && (r_tenths == 4'd9);
    assign w_max  = w_c2 && (r_ones == 4'd9);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_ones     <= '0;
            r_tenths   <= '0;
            r_hund     <= '0;
            r_thou     <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.clear) begin
                r_state    <= S_IDLE;
                r_pre      <= '0;
                r_ones     <= '0;
                r_tenths   <= '0;
                r_hund     <= '0;
                r_thou     <= '0;
                r_running  <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                            r_pre     <= '0;
                            r_ones    <= '0;
                            r_tenths  <= '0;
                            r_hund    <= '0;
                            r_thou    <= '0;
                        end
                    end
                    S_RUN: begin
                        if (bus.stop) begin
                            r_state   <= S_HOLD;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_pre <= w_tick ? '0 : r_pre + 1'b1;
                            if (w_tick && w_max) begin
                                r_state    <= S_OVF;
                                r_running  <= 1'b0;
                                r_overflow <= 1'b1;
                                r_done     <= 1'b1;
                            end else if (w_tick) begin
                                r_thou <= f_inc(r_thou);
                                if (w_c0) r_hund <= f_inc(r_hund);
                                if (w_c1) r_tenths <= f_inc(r_tenths);
                                if (w_c2) r_ones <= f_inc(r_ones);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.running  = r_running;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;

`ifdef BCD_MS_TIMER_LAP_EN
    logic        r_lap_q;
    logic        r_frz;
    logic [15:0] r_lap_d;
    logic        w_leave;
    logic        w_lap_rise;
    logic [15:0] w_live;

    assign w_live     = {r_ones, r_tenths, r_hund, r_thou};
    assign w_lap_rise = bus.lap && !r_lap_q;
    // Any edge that exits RUN must drop the freeze on that same edge
    assign w_leave    = bus.clear || (r_state != S_RUN) || bus.stop ||
                        (w_tick && w_max);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lap_q <= 1'b0;
            r_frz   <= 1'b0;
            r_lap_d <= '0;
        end else begin
            r_lap_q <= bus.lap;
            if (w_leave) begin
                r_frz <= 1'b0;
            end else if (w_lap_rise) begin
                r_frz <= !r_frz;
                if (!r_frz) r_lap_d <= w_live;
            end
        end
    end

    assign {bus.ones, bus.tenths, bus.hundreths, bus.thousandths} =
        r_frz ? r_lap_d : w_live;
`else
    assign bus.ones        = r_ones;
    assign bus.tenths      = r_tenths;
    assign bus.hundreths   = r_hund;
    assign bus.thousandths = r_thou;
`endif
endmodule

// File: tb/tb_bcd_ms_timer.sv
// Self-checking bench for bcd_ms_timer with TICK_DIV=4.
// Lap checks are compiled in when BCD_MS_TIMER_LAP_EN is defined.
module tb_bcd_ms_timer;
    localparam int TD = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    bit   skip_model;

    bcd_ms_timer_if bus ();

    bcd_ms_timer #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: elapsed run cycles divided by TICK_DIV, modes as integers
    int m_mode;
    int m_cnt;
    int m_val;
    bit m_done;

    typedef struct {
        bit rst_n;
        bit st;
        bit sp;
        bit cl;
        int idle;
        int val;
        bit run;
        bit ovf;
        bit dn;
    } vec_t;

    vec_t vec[24];

    function automatic logic [15:0] dig(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input int v, input bit run,
                       input bit ovf, input bit dn);
        logic [18:0] act;
        logic [18:0] exp;
        act = {bus.ones, bus.tenths, bus.hundreths, bus.thousandths,
               bus.running, bus.overflow, bus.done};
        exp = {dig(v), run, ovf, dn};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got digits=%h run=%b ovf=%b done=%b, want digits=%h run=%b ovf=%b done=%b",
                     nm, $time, act[18:3], act[2], act[1], act[0],
                     exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit sp, input bit cl);
        m_done = 1'b0;
        if (!r || cl) begin
            m_mode = 0;
            m_val  = 0;
        end else begin
            case (m_mode)
                0: if (st) begin
                    m_mode = 1;
                    m_cnt  = 0;
                    m_val  = 0;
                end
                1: if (sp) begin
                    m_mode = 2;
                    m_done = 1'b1;
                end else begin
                    m_cnt++;
                    if (m_cnt / TD > 9999) begin
                        m_mode = 3;
                        m_val  = 9999;
                        m_done = 1'b1;
                    end else begin
                        m_val = m_cnt / TD;
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit sp, input bit cl);
        reset_n   = r;
        bus.start = st;
        bus.stop  = sp;
        bus.clear = cl;
        @(posedge clk);
        model_step(r, st, sp, cl);
        @(negedge clk);
        if (!skip_model) chk("model", m_val, m_mode == 1, m_mode == 3, m_done);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        skip_model = 1'b1;
        m_mode     = 0;
        m_cnt      = 0;
        m_val      = 0;
        m_done     = 1'b0;
        reset_n    = 1'b0;
        bus.start  = 1'b1;
        bus.stop   = 1'b0;
        bus.clear  = 1'b0;
`ifdef BCD_MS_TIMER_LAP_EN
        bus.lap    = 1'b0;
`endif

        vec[0]  = '{1, 1, 0, 0, 0,     0,    1, 0, 0};
        vec[1]  = '{1, 0, 1, 0, 492,   123,  0, 0, 1};
        vec[2]  = '{1, 0, 0, 0, 20,    123,  0, 0, 0};
        vec[3]  = '{1, 1, 1, 0, 0,     123,  0, 0, 0};
        vec[4]  = '{1, 0, 0, 1, 0,     0,    0, 0, 0};
        vec[5]  = '{1, 1, 0, 0, 0,     0,    1, 0, 0};
        vec[6]  = '{1, 0, 1, 0, 23,    5,    0, 0, 1};
        vec[7]  = '{1, 0, 0, 1, 0,     0,    0, 0, 0};
        vec[8]  = '{1, 1, 0, 0, 0,     0,    1, 0, 0};
        vec[9]  = '{1, 1, 0, 0, 5,     1,    1, 0, 0};
        vec[10] = '{1, 1, 1, 1, 10,    0,    0, 0, 0};
        vec[11] = '{1, 1, 0, 0, 3,     0,    1, 0, 0};
        vec[12] = '{1, 0, 0, 0, 3995,  999,  1, 0, 0};
        vec[13] = '{1, 0, 0, 0, 3,     1000, 1, 0, 0};
        vec[14] = '{1, 0, 1, 0, 0,     1000, 0, 0, 1};
        vec[15] = '{1, 0, 0, 1, 0,     0,    0, 0, 0};
        vec[16] = '{1, 1, 0, 0, 0,     0,    1, 0, 0};
        vec[17] = '{1, 0, 0, 0, 39999, 9999, 0, 1, 1};
        vec[18] = '{1, 0, 0, 0, 0,     9999, 0, 1, 0};
        vec[19] = '{1, 1, 1, 0, 0,     9999, 0, 1, 0};
        vec[20] = '{1, 0, 0, 1, 0,     0,    0, 0, 0};
        vec[21] = '{1, 1, 0, 0, 0,     0,    1, 0, 0};
        vec[22] = '{0, 0, 0, 0, 7,     0,    0, 0, 0};
        vec[23] = '{1, 0, 0, 0, 0,     0,    0, 0, 0};

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset", 0, 1'b0, 1'b0, 1'b0);
        skip_model = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            idle(vec[i].idle);
            cyc(vec[i].rst_n, vec[i].st, vec[i].sp, vec[i].cl);
            chk($sformatf("vec%0d", i), vec[i].val, vec[i].run,
                vec[i].ovf, vec[i].dn);
        end

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) != 0,
                $urandom_range(9) < 2,
                $urandom_range(99) < 3,
                $urandom_range(99) < 2);
        end

`ifdef BCD_MS_TIMER_LAP_EN
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        skip_model = 1'b1;
        idle(200);
        bus.lap = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        bus.lap = 1'b0;
        chk("lap_freeze", 50, 1'b1, 1'b0, 1'b0);
        idle(40);
        chk("lap_held", 50, 1'b1, 1'b0, 1'b0);
        idle(79);
        bus.lap = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        bus.lap = 1'b0;
        chk("lap_release", 80, 1'b1, 1'b0, 1'b0);
        skip_model = 1'b0;
        idle(39);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("lap_stop", 90, 1'b0, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_ms_timer.md
Name: bcd_ms_timer

Overview:
- Sequential producer of the four BCD digits consumed by the seven-segment decoder: ones, tenths, hundreths, thousandths, i.e. elapsed time X.XXX s at 1 ms resolution.
- Prescales the system clock to a 1 ms tick and runs a cascaded decimal counter with carry.
- Start/stop/clear FSM sits between the reaction-game control logic and the display path.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock); minimum 2.
- PRE_W, $clog2(TICK_DIV), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  level/pulse; begins timing from IDLE.
- stop  in  1  level/pulse; freezes count in RUN.
- clear  in  1  returns to IDLE, zeroes digits.
- ones  out  4  BCD seconds digit, 0-9.
- tenths  out  4  BCD 0.1 s digit.
- hundreths  out  4  BCD 0.01 s digit.
- thousandths  out  4  BCD 0.001 s digit.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to HOLD or OVF.
- overflow  out  1  high in OVF.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE, all digits 0, prescaler 0, running=0, done=0, overflow=0. Reset mid-RUN discards the count; no done pulse.
- States: IDLE, RUN, HOLD, OVF. All outputs registered.
- Input priority each cycle: clear > stop > start.
- clear in any state -> IDLE next cycle; digits 0 and prescaler 0 on the same edge.
- IDLE: start -> RUN; digits 0, prescaler 0. stop ignored.
- RUN: prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - Tick asserted in the cycle prescaler==TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after entering RUN.
- On tick: thousandths+1. A digit at 9 wraps to 0 and carries into the next digit, with all carries resolved in the same cycle (e.g. 0.999 -> 1.000 in one edge).
- Tick while digits == 9.999: digits hold 9999, state -> OVF, overflow=1, done pulses.
- RUN + stop: -> HOLD, digits frozen, done=1 for exactly one cycle. A tick coinciding with stop is discarded, so the value equals the count before that edge.
- HOLD: start and stop ignored; only clear (or reset) leaves.
- OVF: digits 9999, overflow=1; only clear (or reset) leaves. overflow clears with the state.
- done: never high for two consecutive cycles; high only on the edge entering HOLD/OVF.
- Digits never take values 10-15.
- start held high continuously: no effect beyond the first IDLE->RUN transition.

Optional Feature:
- Macro: BCD_MS_TIMER_LAP_EN.
- Defined:
  - Adds input port lap (1 bit).
  - In RUN, lap=1 latches current digits into a display register; outputs show the latched value while the internal count continues.
  - Next lap=1 pulse releases the freeze: outputs track live count again; the toggle is edge-detected.
  - Entering HOLD/OVF or clear forces outputs back to live count.
  - Lap is ignored outside RUN.
- Undefined: no lap port; outputs always show the live count; no extra registers.

Test Plan (TICK_DIV=4 in bench):
- Reset: reset_n low 2 cycles with start=1 -> all digits 0, running=0, done=0, overflow=0; state IDLE after release.
- Timing: start pulse, run 4*123 cycles, stop -> digits 0.123, done exactly one cycle, running=0; hold 20 further cycles -> still 0.123.
- Carry: start, stop after 4*999 then 4*1 more cycles -> 0.999 then 1.000, with no intermediate invalid digit on any cycle.
- Overflow: run 4*10000 cycles -> digits 9.999, overflow=1, single done pulse; clear -> 0.000, overflow=0, IDLE.
- Priority: in RUN assert clear, stop and start together -> IDLE, digits 0, no done pulse. Separately, stop coinciding with a tick -> tick discarded.
- LAP_EN build: lap at 0.050 -> outputs hold 0.050 while internal count advances; lap again at internal 0.080 -> outputs show 0.080 live; stop at 0.090 -> outputs 0.090.
